gseq_stream: RTL

//  Synthesizable, clocked geometric-sequence generator: term[i] = a1 * k**i, i = 0..n-1.

---
 rtl/gseq_pkg.sv | 14 +
 rtl/gseq_mul_sat.sv | 33 +++
 rtl/gseq_stream.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gseq_pkg.sv
// Shared types and constants for the geometric-sequence stream generator.
package gseq_pkg;

  // Run-control states: IDLE waits for start, RUN streams terms, FIN closes the run.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // "ovf" in ASCII; emitted (truncated to the term width) in place of overflowed terms.
  localparam logic [63:0] OVF_MARKER_DEFAULT = 64'h6F7666;

endpackage

// File: rtl/gseq_mul_sat.sv
// Combinational ratio multiplier with sticky overflow detection.
// The product is formed at full width so that anything reaching the
// all-ones term value (or beyond) is flagged rather than silently wrapped.
module gseq_mul_sat
  import gseq_pkg::*;
#(
  parameter int W  = 64,
  parameter int KW = 16
) (
  input  logic [W-1:0]  acc,
  input  logic [KW-1:0] k,
  input  logic          ovf_in,
  output logic [W-1:0]  prod,
  output logic          ovf_out
);

  localparam int PW = W + KW;

  // The all-ones term value is reserved, so it already counts as overflow.
  function automatic logic sat_hit(input logic [PW-1:0] p);
    return (p >= {{KW{1'b0}}, {W{1'b1}}});
  endfunction

  logic [PW-1:0] full;

  // Full-width product, truncated term and sticky overflow flag.
  always_comb begin
    full    = {{KW{1'b0}}, acc} * {{W{1'b0}}, k};
    prod    = full[W-1:0];
    ovf_out = ovf_in | sat_hit(full);
  end

endmodule

// File: rtl/gseq_stream.sv
// Geometric-sequence stream generator: term[i] = a1 * k**i for i = 0..n-1,
// one term per valid/ready handshake, tagged with index, last and overflow.
module gseq_stream
  import gseq_pkg::*;
#(
  parameter int          W          = 64,
  parameter int          KW         = 16,
  parameter int          NW         = 16,
  parameter logic [63:0] OVF_MARKER = OVF_MARKER_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a1,
  input  logic [KW-1:0] k,
  input  logic [NW-1:0] n,
  input  logic          abort,
  output logic          busy,
  output logic          term_valid,
  input  logic          term_ready,
  output logic [W-1:0]  term,
  output logic [NW-1:0] term_idx,
  output logic          term_last,
  output logic          term_ovf,
  output logic          done
);

  localparam logic [W-1:0] MARK = W'(OVF_MARKER);

  state_t        state;
  logic [W-1:0]  acc;
  logic [KW-1:0] k_reg;
  logic [NW-1:0] n_reg;
  logic          ovf;

  logic [W-1:0]  prod;
  logic          ovf_next;
  logic          accept;
  logic          xfer;
  logic          a1_ovf;
  logic [NW-1:0] idx_next;

  gseq_mul_sat #(
    .W  (W),
    .KW (KW)
  ) u_mul (
    .acc     (acc),
    .k       (k_reg),
    .ovf_in  (ovf),
    .prod    (prod),
    .ovf_out (ovf_next)
  );

  // Start acceptance, handshake and next-index decode.
  always_comb begin
    accept   = (state == IDLE) && start && !abort;
    xfer     = (state == RUN) && term_valid && term_ready && !abort;
    a1_ovf   = (a1 == {W{1'b1}});
    idx_next = term_idx + NW'(1);
  end

  // Run operands and accumulator; these only carry data, so they are not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc   <= a1;
      k_reg <= k;
      n_reg <= n;
    end else if (xfer && !term_last) begin
      acc <= prod;
    end
  end

  // Run-control FSM with registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      term_valid <= 1'b0;
      term       <= '0;
      term_idx   <= '0;
      term_last  <= 1'b0;
      term_ovf   <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (n != '0) begin
              state      <= RUN;
              term_valid <= 1'b1;
              term       <= a1_ovf ? MARK : a1;
              term_idx   <= '0;
              term_last  <= (n == NW'(1));
              term_ovf   <= a1_ovf;
              ovf        <= a1_ovf;
            end else begin
              state <= FIN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            term_valid <= 1'b0;
            term       <= '0;
            term_idx   <= '0;
            term_last  <= 1'b0;
            term_ovf   <= 1'b0;
            ovf        <= 1'b0;
          end else if (xfer) begin
            if (term_last) begin
              state      <= FIN;
              term_valid <= 1'b0;
              term       <= '0;
              term_idx   <= '0;
              term_last  <= 1'b0;
              term_ovf   <= 1'b0;
              ovf        <= 1'b0;
            end else begin
              term      <= ovf_next ? MARK : prod;
              term_idx  <= idx_next;
              term_last <= (idx_next == (n_reg - NW'(1)));
              term_ovf  <= ovf_next;
              ovf       <= ovf_next;
            end
          end
        end
        FIN: begin
          // The done pulse appears as the run returns to IDLE, unless aborted.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= !abort;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
